// File: rtl/sqrt_seq.sv
// sqrt_seq: sequential integer square root, digit-by-digit (restoring),
// one root bit per clock, with valid/ready handshakes on input and output.
// y = floor(sqrt(x)), rem = x - y_trunc^2.
// Optional: define SQRT_ROUND_EN to make y round-to-nearest (saturating);
// rem always reports the truncated-root remainder.
module sqrt_seq #(
  parameter int WIDTH     = 21,
  parameter int OUT_WIDTH = (WIDTH + 1) / 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     x,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] y,
  output logic [OUT_WIDTH:0]   rem,
  output logic                 busy
);

  // Operand is processed in bit pairs, so odd widths are zero-extended.
  localparam int XW = 2 * OUT_WIDTH;
  // Partial remainder / test value carry two extra bits so the compare
  // never overflows on the final step.
  localparam int PW = OUT_WIDTH + 2;
  localparam int CW = $clog2(OUT_WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state;
  state_t               state_next;
  logic [XW-1:0]        op;
  logic [PW-1:0]        part;
  logic [OUT_WIDTH-1:0] root;
  logic [CW-1:0]        cnt;

  logic [1:0]           pair;
  logic [PW-1:0]        trial;
  logic [PW-1:0]        test;
  logic                 fits;
  logic [PW-1:0]        part_step;
  logic [OUT_WIDTH-1:0] root_step;
  logic [OUT_WIDTH-1:0] y_final;

  // One restoring step: bring down the next pair and try to subtract 4r+1.
  always_comb begin
    pair      = op[XW-1 -: 2];
    trial     = (part << 2) | PW'(pair);
    test      = {root, 2'b01};
    fits      = (trial >= test);
    part_step = fits ? (trial - test) : trial;
    root_step = (root << 1) | OUT_WIDTH'(fits);
  end

`ifdef SQRT_ROUND_EN
  logic round_up;

  // Round up when x - r^2 > r, i.e. x > (r + 0.5)^2; saturate at all-ones.
  always_comb begin
    round_up = (part_step > PW'(root_step));
    y_final  = (round_up && !(&root_step)) ? (root_step + OUT_WIDTH'(1)) : root_step;
  end
`else
  // Truncated root is presented as-is.
  always_comb begin
    y_final = root_step;
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs; flush overrides every transition.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (cnt == '0) state_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  // Datapath: load on accept, iterate in CALC, capture results on the last step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op   <= '0;
      part <= '0;
      root <= '0;
      cnt  <= '0;
      y    <= '0;
      rem  <= '0;
    end else if (!flush) begin
      if (state == IDLE && in_valid) begin
        op   <= XW'(x);
        part <= '0;
        root <= '0;
        cnt  <= CW'(OUT_WIDTH - 1);
      end else if (state == CALC) begin
        op   <= op << 2;
        part <= part_step;
        root <= root_step;
        cnt  <= cnt - CW'(1);
        if (cnt == '0) begin
          y   <= y_final;
          rem <= part_step[OUT_WIDTH:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_sqrt_seq.sv
// tb_sqrt_seq: directed vectors for sqrt_seq (WIDTH=21 main instance and a
// WIDTH=20 instance for the even-width / saturation corner), checked both
// against hand-computed literals and an arithmetic square-root model.
`timescale 1ns/1ps
module tb_sqrt_seq;

  localparam int W   = 21;
  localparam int OW  = 11;
  localparam int W2  = 20;
  localparam int OW2 = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  x;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] y;
  logic [OW:0]   rem;
  logic          busy;

  logic           in_valid2;
  logic           in_ready2;
  logic [W2-1:0]  x2;
  logic           out_valid2;
  logic [OW2-1:0] y2;
  logic [OW2:0]   rem2;
  logic           busy2;

  int checks = 0;
  int errors = 0;

  logic         have_exp = 1'b0;
  logic [W-1:0] exp_x    = '0;

  always #5 clk = ~clk;

  sqrt_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .x(x), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .rem(rem), .busy(busy)
  );

  sqrt_seq #(.WIDTH(W2)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(in_valid2),
    .in_ready(in_ready2), .x(x2), .out_valid(out_valid2), .out_ready(1'b1),
    .y(y2), .rem(rem2), .busy(busy2)
  );

  // Reference: plain integer square root.
  function automatic longint isqrt(input longint v);
    longint r;
    r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  function automatic longint model_y(input longint v, input int ow);
    longint r;
    r = isqrt(v);
`ifdef SQRT_ROUND_EN
    if (v - r * r > r) begin
      r = r + 1;
      if (r > (longint'(1) << ow) - 1) r = (longint'(1) << ow) - 1;
    end
`endif
    return r;
  endfunction

  task automatic chk(input string name, input longint got, input longint want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  // Every cycle a result is presented, it must match the model for the
  // operand currently in flight.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      checks++;
      if (!have_exp) begin
        errors++;
        $display("FAIL unexpected_out_valid y %0d rem %0d", y, rem);
      end else if (longint'(y) != model_y(longint'(exp_x), OW) ||
                   longint'(rem) != longint'(exp_x) - isqrt(longint'(exp_x)) ** 2) begin
        errors++;
        $display("FAIL model x %0d got y %0d rem %0d want y %0d rem %0d", exp_x, y, rem,
                 model_y(longint'(exp_x), OW),
                 longint'(exp_x) - isqrt(longint'(exp_x)) ** 2);
      end
    end
  end

  // Present an operand at a negedge and let it be taken on the next posedge.
  task automatic accept(input logic [W-1:0] xv);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_before_accept", in_ready, 1);
    exp_x    = xv;
    have_exp = 1'b1;
    in_valid = 1'b1;
    x        = xv;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Count edges from the accept edge until out_valid; ends on a negedge.
  task automatic wait_result(output int n);
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (out_valid) break;
    end
  endtask

  task automatic run(input logic [W-1:0] xv, input longint ey, input longint erem);
    int n;
    accept(xv);
    wait_result(n);
    $display("op x=%0d y=%0d rem=%0d latency=%0d", xv, y, rem, n);
    chk("latency", n, OW);
    chk("y_literal", y, ey);
    chk("rem_literal", rem, erem);
    @(posedge clk);
    have_exp = 1'b0;
    @(negedge clk);
    chk("idle_after_handshake_in_ready", in_ready, 1);
    chk("idle_after_handshake_out_valid", out_valid, 0);
  endtask

  int tx   [9] = '{0, 1, 2, 3, 90, 91, 99, 100, 2097151};
  int ty_t [9] = '{0, 1, 1, 1, 9, 9, 9, 10, 1448};
  int ty_r [9] = '{0, 1, 1, 2, 9, 10, 10, 10, 1448};
  int trem [9] = '{0, 0, 1, 2, 9, 10, 18, 0, 447};

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int seen;
    longint ey;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; x = '0; out_ready = 1'b1;
    in_valid2 = 1'b0; x2 = '0;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_y", y, 0);
    chk("reset_rem", rem, 0);
    chk("reset_in_ready2", in_ready2, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Main vectors.
    for (int i = 0; i < 9; i++) begin
`ifdef SQRT_ROUND_EN
      ey = ty_r[i];
`else
      ey = ty_t[i];
`endif
      run(W'(tx[i]), ey, trem[i]);
    end

    // Backpressure: hold out_ready low, in_valid must be ignored.
`ifdef SQRT_ROUND_EN
    ey = 10;
`else
    ey = 9;
`endif
    out_ready = 1'b0;
    accept(W'(99));
    wait_result(n);
    chk("bp_latency", n, OW);
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      x = W'(5);
      @(posedge clk);
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_y", y, ey);
      chk("bp_rem", rem, 18);
    end
    $display("op backpressure x=99 held 20 cycles y=%0d rem=%0d", y, rem);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    have_exp = 1'b0;
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_release_out_valid", out_valid, 0);
    out_ready = 1'b1;

    // Flush on the 5th CALC cycle.
    accept(W'(12345));
    repeat (4) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    have_exp = 1'b0;
    #1 flush = 1'b0;
    chk("flush_in_ready", in_ready, 1);
    chk("flush_busy", busy, 0);
    chk("flush_out_valid", out_valid, 0);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("flush_no_result", seen, 0);
    $display("op flush x=12345 discarded");
    run(W'(144), 12, 0);

    // Asynchronous reset mid-calculation.
    accept(W'(2097151));
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    have_exp = 1'b0;
    chk("areset_out_valid", out_valid, 0);
    chk("areset_in_ready", in_ready, 1);
    chk("areset_busy", busy, 0);
    chk("areset_y", y, 0);
    chk("areset_rem", rem, 0);
    $display("op async reset mid-CALC");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(W'(100), 10, 0);

    // Even width, top of range: rounding would overflow, so y saturates.
    in_valid2 = 1'b1;
    x2 = W2'(1048575);
    @(posedge clk);
    #1 in_valid2 = 1'b0;
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (out_valid2) break;
    end
    $display("op w20 x=1048575 y=%0d rem=%0d latency=%0d", y2, rem2, n);
    chk("w20_latency", n, OW2);
    chk("w20_y", y2, 1023);
    chk("w20_rem", rem2, 2046);
    chk("w20_model_y", y2, model_y(1048575, OW2));

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sqrt_seq.md
Name: sqrt_seq

Overview:
Parametrised, multi-cycle integer square root; the successor to the fixed-range combinational root table.
- Computes floor(sqrt(x)) and the remainder x - root^2 for any x up to WIDTH bits.
- Digit-by-digit (restoring) algorithm, one result bit per clock.
- Valid/ready handshakes on both input and output, so it sits between pipeline stages of the datapath.

Parameters:
- WIDTH, 21, bit width of operand x; any value >= 2.
- OUT_WIDTH, (WIDTH+1)/2, width of root; derived, not to be overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous abort; returns block to IDLE.
- in_valid  input  1  operand x is valid.
- in_ready  output  1  block can accept an operand.
- x  input  WIDTH  unsigned operand.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- y  output  OUT_WIDTH  unsigned root.
- rem  output  OUT_WIDTH+1  remainder x - y_trunc^2 (always the truncated-root remainder).
- busy  output  1  high in CALC or DONE.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, y=0, rem=0, internal operand/partial registers=0.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch x (zero-extended to 2*OUT_WIDTH bits when WIDTH is odd).
  - Clear root and remainder accumulators, load bit counter = OUT_WIDTH-1, go to CALC.
- CALC:
  - in_ready=0.
  - Each cycle, shift the next 2 operand bits into the partial remainder: trial = (partial<<2)|pair.
  - Test value t = (root<<2)|1.
  - If trial >= t: partial = trial - t, root = (root<<1)|1. Else: partial = trial, root = root<<1.
  - After the step with counter=0, go to DONE. Otherwise decrement the counter.
- DONE:
  - out_valid=1; y and rem are stable and held until out_ready.
  - On out_valid&&out_ready, go to IDLE next cycle.
  - in_ready stays 0 in DONE, so there is no accept in the handoff cycle.
- Latency:
  - Accepting edge at cycle 0; out_valid high from cycle OUT_WIDTH.
  - 11 cycles for the default WIDTH.
  - Throughput is one result per OUT_WIDTH+2 cycles with out_ready tied high.
- Uniform latency: no early-out for x=0 or small x; latency is data-independent.
- Arithmetic widths:
  - Partial remainder and test value are OUT_WIDTH+2 bits wide, so the compare never overflows.
  - rem max = 2*root, which fits OUT_WIDTH+1 bits.
- Backpressure: out_ready low holds DONE indefinitely; y and rem must not change.
- Flush:
  - flush=1 in any state forces IDLE next edge with out_valid=0.
  - Flush has priority over in_valid and out_ready in the same cycle; an in-flight operand is discarded.
  - y and rem keep their last values but are don't-care while out_valid=0.
- Reset mid-operation: immediate return to reset values; no partial result is ever presented.
- Outputs are registered; no combinational path from x to y.

Optional Feature:
- Macro: SQRT_ROUND_EN.
- Defined: y is round-to-nearest.
  - In the DONE-entry cycle, if the partial remainder > truncated root, y = root+1. Otherwise y = root.
  - If root+1 would overflow OUT_WIDTH (even WIDTH, x near max), y saturates to all-ones.
  - rem still reports the truncated remainder.
  - Latency is unchanged.
- Undefined: y = floor(sqrt(x)); no rounding logic is synthesised.

Test Plan:
- WIDTH=21: reset, then x=0 -> y=0, rem=0, out_valid exactly 11 cycles after accept.
- x=99 -> y=9, rem=18; x=100 -> y=10, rem=0; x=2097151 -> y=1448, rem=447.
- SQRT_ROUND_EN defined:
  - x=90 -> y=9; x=91 -> y=10; x=99 -> y=10.
  - WIDTH=20, x=1048575 -> y=1023 (saturated), rem=2046.
- Backpressure: out_ready held low 20 cycles after result -> y/rem stable, in_ready=0, in_valid ignored; out_ready pulse -> in_ready=1 next cycle.
- Flush asserted on 5th CALC cycle of x=12345 -> out_valid never rises, IDLE next cycle; then x=144 -> y=12, rem=0.
- rst_n asserted mid-CALC, asynchronously between edges -> outputs at reset values immediately; new operand after release computes correctly.
